sha256_msg_sequencer: RTL and testbench

Message-level controller for the `sha256_top` block core. It accepts a message as a 32-bit big-endian word stream, assembles 512-bit blocks, and applies FIPS 180-4 padding with the 0x80 marker, zero fill and 64-bit bit length. It issues each block to the core with its start/valid handshake, waits for `comp_done`, and presents the final 256-bit digest. It re-initialises the core between messages by pulsing the core's reset.

---
 rtl/sha256_msg_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_sha256_msg_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sequencer.sv
// ---------------------------------------------------------------------------
// sha256_msg_sequencer
//
// Message-level controller that sits in front of a SHA-256 block core.
// It takes a message as a stream of 32-bit big-endian words, packs 512-bit
// blocks, adds the FIPS 180-4 padding (0x80 marker, zero fill and 64-bit
// bit length), and hands each block to the core. The core is reset between
// messages. The final digest is captured and announced with a one-cycle
// pulse.
//
// Optional feature macro: SHA256_SEQ_ABORT_EN (adds the 'abort' input).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   s_data/s_valid/s_ready/s_last/s_bytes
//                         message word stream; s_bytes = valid bytes in the
//                         last word (0 means 4)
//   core_rst_n            registered active-low reset to the core
//   core_start_block      one-cycle start strobe to the core
//   core_block_in         512-bit block, stable from ISSUE through WAIT
//   core_block_valid      one-cycle block-valid strobe to the core
//   core_busy, core_comp_done, core_hash_out
//                         status and result from the core
//   busy                  high outside IDLE and DONE
//   digest, digest_valid  final hash and its one-cycle update pulse
//   blk_count             blocks issued for the current message (wraps)
//   dbg_state             current FSM state
//   abort                 (SHA256_SEQ_ABORT_EN only) drop the message
//
// Handshakes: a word moves when s_valid & s_ready are both high on a rising
// clock edge; s_ready is high only in FILL and does not depend on s_valid.
// Towards the core, core_start_block is high for the cycle after ISSUE sees
// core_busy low, and core_block_valid is high for the cycle after that.
// ---------------------------------------------------------------------------
module sha256_msg_sequencer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_last,
  input  logic [1:0]   s_bytes,
`ifdef SHA256_SEQ_ABORT_EN
  input  logic         abort,
`endif
  output logic         core_rst_n,
  output logic         core_start_block,
  output logic [511:0] core_block_in,
  output logic         core_block_valid,
  input  logic         core_busy,
  input  logic         core_comp_done,
  input  logic [255:0] core_hash_out,
  output logic         busy,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic [15:0]  blk_count,
  output logic [3:0]   dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_INIT  = 4'd1,
    S_FILL  = 4'd2,
    S_PAD   = 4'd3,
    S_ISSUE = 4'd4,
    S_FEED  = 4'd5,
    S_WAIT  = 4'd6,
    S_GAP   = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t         state_q;
  logic [511:0]   buf_q;
  logic [3:0]     widx_q;
  logic [63:0]    msg_bits_q;
  logic [15:0]    blk_count_q;
  logic           marker_done_q;
  logic           final_q;
  logic           last_q;        // message terminated (s_last seen)
  logic [2:0]     lbytes_q;      // valid bytes in the last word, 1..4
  logic           core_rst_n_q;
  logic           start_q;
  logic           valid_q;
  logic [255:0]   digest_q;
  logic           digest_valid_q;

  logic [511:0]   fill_blk_d;
  logic [511:0]   pad_blk_d;
  logic [511:0]   gap_blk_d;
  logic [6:0]     pad_pos_d;     // byte offset of the marker in the block
  logic           pad_fits_d;
  logic [5:0]     bits_inc_d;
  logic           abort_hit;

`ifdef SHA256_SEQ_ABORT_EN
  assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_DONE);
`else
  assign abort_hit = 1'b0;
`endif

  // Bits contributed by the word currently offered.
  assign bits_inc_d = (s_last && (s_bytes != 2'd0)) ? {1'b0, s_bytes, 3'b000} : 6'd32;

  // Buffer with the offered word written at widx (word 0 is the MSBs).
  always_comb begin
    fill_blk_d = buf_q;
    for (int w = 0; w < 16; w++) begin
      if (widx_q == 4'(w)) fill_blk_d[511-32*w -: 32] = s_data;
    end
  end

  // Padding of the block holding the last message word. pad_pos is 64 when
  // the last word filled the block: nothing is written, and the marker is
  // deferred to the following pad block.
  always_comb begin
    pad_pos_d  = {1'b0, widx_q, 2'b00} + {4'b0000, lbytes_q};
    pad_fits_d = (pad_pos_d <= 7'd55);
    pad_blk_d  = buf_q;
    for (int b = 0; b < 64; b++) begin
      if (7'(b) == pad_pos_d) begin
        pad_blk_d[511-8*b -: 8] = 8'h80;
      end else if (7'(b) > pad_pos_d) begin
        pad_blk_d[511-8*b -: 8] = 8'h00;
      end
    end
    if (pad_fits_d) pad_blk_d[63:0] = msg_bits_q;
  end

  // Extra block carrying only (maybe) the marker and the length.
  always_comb begin
    gap_blk_d = '0;
    if (!marker_done_q) gap_blk_d[511:504] = 8'h80;
    gap_blk_d[63:0] = msg_bits_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      buf_q          <= '0;
      widx_q         <= '0;
      msg_bits_q     <= '0;
      blk_count_q    <= '0;
      marker_done_q  <= 1'b0;
      final_q        <= 1'b0;
      last_q         <= 1'b0;
      lbytes_q       <= 3'd4;
      core_rst_n_q   <= 1'b0;
      start_q        <= 1'b0;
      valid_q        <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else if (abort_hit) begin
      // The core is reset for one cycle so nothing of this message survives.
      state_q        <= S_IDLE;
      core_rst_n_q   <= 1'b0;
      start_q        <= 1'b0;
      valid_q        <= 1'b0;
      digest_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          core_rst_n_q   <= 1'b1;
          digest_valid_q <= 1'b0;
          if (s_valid) begin
            core_rst_n_q <= 1'b0;
            state_q      <= S_INIT;
          end
        end
        S_INIT: begin
          core_rst_n_q  <= 1'b1;
          buf_q         <= '0;
          widx_q        <= '0;
          msg_bits_q    <= '0;
          blk_count_q   <= '0;
          marker_done_q <= 1'b0;
          final_q       <= 1'b0;
          last_q        <= 1'b0;
          state_q       <= S_FILL;
        end
        S_FILL: begin
          if (s_valid) begin
            buf_q      <= fill_blk_d;
            msg_bits_q <= msg_bits_q + {58'd0, bits_inc_d};
            if (s_last) begin
              last_q   <= 1'b1;
              lbytes_q <= (s_bytes == 2'd0) ? 3'd4 : {1'b0, s_bytes};
              state_q  <= S_PAD;
            end else if (widx_q == 4'd15) begin
              state_q <= S_ISSUE;
            end else begin
              widx_q <= widx_q + 4'd1;
            end
          end
        end
        S_PAD: begin
          buf_q <= pad_blk_d;
          if (pad_pos_d != 7'd64) marker_done_q <= 1'b1;
          if (pad_fits_d) final_q <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!core_busy) begin
            start_q <= 1'b1;
            state_q <= S_FEED;
          end
        end
        S_FEED: begin
          start_q     <= 1'b0;
          valid_q     <= 1'b1;
          blk_count_q <= blk_count_q + 16'd1;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          valid_q <= 1'b0;
          if (core_comp_done) begin
            if (final_q) digest_q <= core_hash_out;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (final_q) begin
            digest_valid_q <= 1'b1;
            state_q        <= S_DONE;
          end else if (!last_q) begin
            buf_q   <= '0;
            widx_q  <= '0;
            state_q <= S_FILL;
          end else begin
            buf_q         <= gap_blk_d;
            marker_done_q <= 1'b1;
            final_q       <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end
        S_DONE: begin
          digest_valid_q <= 1'b0;
          state_q        <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_ready          = (state_q == S_FILL);
  assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
  assign core_rst_n       = core_rst_n_q;
  assign core_start_block = start_q;
  assign core_block_valid = valid_q;
  assign core_block_in    = buf_q;
  assign digest           = digest_q;
  assign digest_valid     = digest_valid_q;
  assign blk_count        = blk_count_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for sha256_msg_sequencer. A behavioural SHA-256 core answers the
// sequencer; every block it receives is compared with a block padded
// independently by the bench, and every digest with a digest computed by the
// bench's own SHA-256 model plus the published digest words.
// ---------------------------------------------------------------------------
module tb_sha256_msg_sequencer;

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_FILL = 4'd2;

  typedef struct {
    int          len;
    int          pat;
    int          exp_blocks;
    bit          known;
    logic [31:0] d_hi;
    logic [31:0] d_lo;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic [1:0]   s_bytes = '0;
  logic         abort = 1'b0;
  logic         s_ready, core_rst_n, core_start_block, core_block_valid;
  logic [511:0] core_block_in;
  logic         busy, digest_valid;
  logic [255:0] digest;
  logic [15:0]  blk_count;
  logic [3:0]   dbg_state;
  logic         cm_busy = 1'b0;
  logic         cm_done = 1'b0;
  logic [255:0] cm_h = IV;

  always #5 clk = ~clk;

  sha256_msg_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_bytes(s_bytes),
`ifdef SHA256_SEQ_ABORT_EN
    .abort(abort),
`endif
    .core_rst_n(core_rst_n), .core_start_block(core_start_block), .core_block_in(core_block_in),
    .core_block_valid(core_block_valid), .core_busy(cm_busy), .core_comp_done(cm_done),
    .core_hash_out(cm_h), .busy(busy), .digest(digest), .digest_valid(digest_valid),
    .blk_count(blk_count), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [511:0] exp_blk_q[$];
  logic [255:0] exp_dig_q[$];
  int n_checks = 0, n_fail = 0, n_dv = 0, dvt = 0;
  int rst_pulses = 0, exp_rst = 0, cyc = 0, last_done_cyc = 0;
  logic [7:0] mbuf [512];
  logic [7:0] pm [576];
  vec_t vecs [11];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference SHA-256 ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  function automatic logic [7:0] msg_byte(input int pat, input int i);
    case (pat)
      0: return (i == 0) ? 8'h61 : (i == 1) ? 8'h62 : 8'h63;
      1: begin
        if (i < 26) return 8'(97 + i);
        else if (i < 36) return 8'(48 + i - 26);
        else if (i < 60) return 8'(65 + i - 36);
        else return 8'h5a;
      end
      2: return 8'h61;
      3: return 8'(97 + i / 4 + i % 4);
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic logic [511:0] pm_blk(input int j);
    logic [511:0] r;
    for (int b = 0; b < 64; b++) r[511-8*b -: 8] = pm[64*j + b];
    return r;
  endfunction

  // ---------------- behavioural core + digest monitor ----------------
  int           cm_cnt = 0;
  logic [511:0] cm_blk = '0;
  bit           prev_rst = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!core_rst_n && prev_rst) rst_pulses++;
    prev_rst = core_rst_n;
    if (!core_rst_n) begin
      cm_h = IV;
      cm_cnt = 0;
      cm_busy <= 1'b0;
      cm_done <= 1'b0;
    end else begin
      cm_done <= 1'b0;
      if (core_start_block) cm_busy <= 1'b1;
      if (core_block_valid) begin
        if (exp_blk_q.size() == 0) begin
          chk_blk("unexpected_block", core_block_in, '0);
        end else begin
          chk_blk("block", core_block_in, exp_blk_q.pop_front());
        end
        cm_blk = core_block_in;
        cm_cnt = $urandom_range(3, 20);
      end else if (cm_cnt > 0) begin
        cm_cnt--;
        if (cm_cnt == 0) begin
          chk_blk("block_stable", core_block_in, cm_blk);
          cm_h = sha_comp(cm_h, cm_blk);
          cm_done <= 1'b1;
          cm_busy <= 1'b0;
          last_done_cyc = cyc;
        end
      end
    end
    if (rst_n && digest_valid) begin
      n_dv++;
      chk("dv_latency", 256'(cyc - last_done_cyc), 256'd2);
      if (exp_dig_q.size() == 0) chk("unexpected_digest", digest, '0);
      else chk("digest", digest, exp_dig_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Sends the first 'lim' words of a message (all of them when lim < 0).
  // Leaves s_valid high on return so back-to-back messages can be chained.
  task automatic send_msg(input int len, input int pat, input int lim, input bit gaps);
    int nw, nsend, nb, n;
    bit full;
    logic [63:0] bits;
    logic [255:0] d;
    for (int i = 0; i < len; i++) mbuf[i] = msg_byte(pat, i);
    for (int i = 0; i < 576; i++) pm[i] = 8'h00;
    for (int i = 0; i < len; i++) pm[i] = mbuf[i];
    pm[len] = 8'h80;
    nb = (len + 72) / 64;
    bits = 64'(len) * 64'd8;
    for (int k = 0; k < 8; k++) pm[nb*64 - 8 + k] = bits[63-8*k -: 8];
    nw = (len + 3) / 4;
    nsend = (lim < 0) ? nw : lim;
    full = (nsend == nw);
    for (int j = 0; j < (full ? nb : nsend / 16); j++) exp_blk_q.push_back(pm_blk(j));
    if (full) begin
      d = IV;
      for (int j = 0; j < nb; j++) d = sha_comp(d, pm_blk(j));
      exp_dig_q.push_back(d);
    end
    for (int i = 0; i < nsend; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      for (int k = 0; k < 4; k++)
        s_data[31-8*k -: 8] = (4*i + k < len) ? mbuf[4*i + k] : 8'($urandom_range(0, 255));
      s_last  = full && (i == nw - 1);
      s_bytes = s_last ? 2'(len % 4) : 2'($urandom_range(0, 3));
      s_valid = 1'b1;
      n = 0;
      while (!s_ready && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 3000) begin
        chk("s_ready_timeout", 256'(n), 256'd0);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_dv(input int target);
    int n = 0;
    while (n_dv < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("dv_count", 256'(n_dv), 256'(target));
  endtask

  task automatic end_stream();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0]  = '{3,   0, 1, 1'b1, 32'hba7816bf, 32'hf20015ad};
    vecs[1]  = '{61,  1, 2, 1'b1, 32'h15f42e41, 32'h4eeb19fe};
    vecs[2]  = '{256, 2, 5, 1'b1, 32'h02d7160d, 32'hc65ce5fe};
    vecs[3]  = '{56,  3, 2, 1'b1, 32'h248d6a61, 32'h19db06c1};
    vecs[4]  = '{1,   4, 1, 1'b0, 32'h0, 32'h0};
    vecs[5]  = '{4,   4, 1, 1'b0, 32'h0, 32'h0};
    vecs[6]  = '{55,  4, 1, 1'b0, 32'h0, 32'h0};
    vecs[7]  = '{64,  4, 2, 1'b0, 32'h0, 32'h0};
    vecs[8]  = '{62,  4, 2, 1'b0, 32'h0, 32'h0};
    vecs[9]  = '{63,  4, 2, 1'b0, 32'h0, 32'h0};
    vecs[10] = '{120, 4, 3, 1'b0, 32'h0, 32'h0};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 256'(s_ready), 256'd0);
    chk("rst_core_rst_n", 256'(core_rst_n), 256'd0);
    chk("rst_start", 256'(core_start_block), 256'd0);
    chk("rst_block_valid", 256'(core_block_valid), 256'd0);
    chk("rst_block_in", core_block_in[511:256] | core_block_in[255:0], '0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_digest", digest, '0);
    chk("rst_digest_valid", 256'(digest_valid), 256'd0);
    chk("rst_blk_count", 256'(blk_count), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("core_rst_release", 256'(core_rst_n), 256'd1);
    chk("idle_after_reset", 256'(dbg_state), 256'(ST_IDLE));

    // Table-driven messages
    for (int v = 0; v < 11; v++) begin
      exp_rst++;
      dvt++;
      send_msg(vecs[v].len, vecs[v].pat, -1, 1'b1);
      end_stream();
      wait_dv(dvt);
      @(negedge clk);
      chk($sformatf("blk_count_len%0d", vecs[v].len), 256'(blk_count), 256'(vecs[v].exp_blocks));
      if (vecs[v].known) begin
        chk($sformatf("digest_hi_len%0d", vecs[v].len), 256'(digest[255:224]), 256'(vecs[v].d_hi));
        chk($sformatf("digest_lo_len%0d", vecs[v].len), 256'(digest[31:0]), 256'(vecs[v].d_lo));
      end
      chk("core_rst_pulses", 256'(rst_pulses), 256'(exp_rst));
      chk("blocks_drained", 256'(exp_blk_q.size()), 256'd0);
      chk("busy_after_done", 256'(busy), 256'd0);
    end

    // Back-to-back "abc" with s_valid held across the boundary
    exp_rst += 2;
    dvt += 2;
    send_msg(3, 0, -1, 1'b0);
    send_msg(3, 0, -1, 1'b0);
    end_stream();
    wait_dv(dvt);
    chk("b2b_digest", digest, ABC_D);
    chk("b2b_rst_pulses", 256'(rst_pulses), 256'(exp_rst));

    // Reset in the middle of a message
    exp_rst++;
    send_msg(120, 4, 20, 1'b1);
    end_stream();
    repeat (40) @(negedge clk);
    chk("mid_first_block_done", 256'(exp_blk_q.size()), 256'd0);
    chk("mid_state_fill", 256'(dbg_state), 256'(ST_FILL));
    chk("mid_blk_count", 256'(blk_count), 256'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s_ready", 256'(s_ready), 256'd0);
    chk("mid_rst_busy", 256'(busy), 256'd0);
    chk("mid_rst_blk_count", 256'(blk_count), 256'd0);
    chk("mid_rst_digest", digest, '0);
    chk("mid_rst_core_rst_n", 256'(core_rst_n), 256'd0);
    chk("mid_rst_block_in", core_block_in[511:256] | core_block_in[255:0], '0);
    exp_rst++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_dig_q.delete();
    exp_blk_q.delete();
    exp_rst++;
    dvt++;
    send_msg(3, 0, -1, 1'b1);
    end_stream();
    wait_dv(dvt);
    chk("after_reset_digest", digest, ABC_D);
    chk("after_reset_rst_pulses", 256'(rst_pulses), 256'(exp_rst));

`ifdef SHA256_SEQ_ABORT_EN
    // Abort while the core is working on block 2 of 256 x 'a'
    begin
      int n = 0;
      exp_rst++;
      send_msg(256, 2, 32, 1'b1);
      end_stream();
      while (blk_count != 16'd2 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("abort_reach_block2", 256'(blk_count), 256'd2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      exp_rst++;
      repeat (30) @(negedge clk);
      chk("abort_no_dv", 256'(n_dv), 256'(dvt));
      chk("abort_idle", 256'(dbg_state), 256'(ST_IDLE));
      chk("abort_blocks", 256'(exp_blk_q.size()), 256'd0);
      chk("abort_rst_pulses", 256'(rst_pulses), 256'(exp_rst));
      exp_rst++;
      dvt++;
      send_msg(3, 0, -1, 1'b1);
      end_stream();
      wait_dv(dvt);
      chk("abort_then_abc", digest, ABC_D);
    end
`endif

    repeat (5) @(negedge clk);
    chk("no_stray_digest", 256'(n_dv), 256'(dvt));
    chk("no_pending_digest", 256'(exp_dig_q.size()), 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
